// File: rtl/test_sequencer_pkg.sv
// test_sequencer_pkg: shared FSM state encoding and default sizing for the test sequencer
package test_sequencer_pkg;
  typedef enum logic [2:0] {IDLE, CLEAR, RUN, DRAIN, CAPTURE, DONE} state_t;
  localparam int CLEAR_CYCLES_DEF = 4;
  localparam int CTR_W_DEF = 32;
endpackage

// File: rtl/test_sequencer_seq_counter.sv
// seq_counter: loadable down-counter with zero flag, times the CLEAR, RUN and DRAIN phases
// Ports: clk_dut/reset clock and async reset; ld/ld_val load a new count;
// dec counts down, stopping at zero; zero is high while the count is zero.
module seq_counter #(
  parameter int W = 32
) (
  input  logic         clk_dut,
  input  logic         reset,
  input  logic         ld,
  input  logic [W-1:0] ld_val,
  input  logic         dec,
  output logic         zero
);
  logic [W-1:0] cnt;
  always_ff @(posedge clk_dut or posedge reset)
    if (reset) cnt <= '0;
    else if (ld) cnt <= ld_val;
    else if (dec && !zero) cnt <= cnt - W'(1);
  assign zero = cnt == '0;
endmodule

// File: rtl/test_sequencer.sv
// test_sequencer: sequences a test run through clear, stimulus, drain and result capture
// Ports: clk_dut/reset clock and async reset; i_start/i_abort run control;
// i_num_vectors/i_drain run lengths latched at start; i_data_ctr/i_event_ctr counters to capture;
// o_tb_reset/o_enable/o_freeze testbench controls; o_busy/o_done/o_pass/o_aborted status;
// o_res_data/o_res_events captured counters.
module test_sequencer
  import test_sequencer_pkg::*;
#(
  parameter int CLEAR_CYCLES = CLEAR_CYCLES_DEF,
  parameter int CTR_W = CTR_W_DEF
) (
  input  logic             clk_dut,
  input  logic             reset,
  input  logic             i_start,
  input  logic             i_abort,
  input  logic [CTR_W-1:0] i_num_vectors,
  input  logic [7:0]       i_drain,
  input  logic [CTR_W-1:0] i_data_ctr,
  input  logic [CTR_W-1:0] i_event_ctr,
  output logic             o_tb_reset,
  output logic             o_enable,
  output logic             o_freeze,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_pass,
  output logic             o_aborted,
  output logic [CTR_W-1:0] o_res_data,
  output logic [CTR_W-1:0] o_res_events
);
  state_t state, state_n, drain_st;
  logic [CTR_W-1:0] num_q, ld_val, drain_ld;
  logic [7:0] drain_q;
  logic cap_q, ld, cnt_zero, timed, start_go, abort_go;
  assign timed = state inside {CLEAR, RUN, DRAIN};
  assign start_go = state == IDLE && i_start;
  assign abort_go = timed && i_abort;
  // a zero drain length skips DRAIN entirely
  assign drain_st = drain_q == '0 ? CAPTURE : DRAIN;
  assign drain_ld = CTR_W'(drain_q - 8'd1);
  // each timed phase loads length-1 on entry and leaves when the counter reads zero
  always_comb begin
    state_n = state;
    ld = 1'b0;
    ld_val = '0;
    case (state)
      IDLE: if (i_start) begin
        state_n = CLEAR;
        ld = 1'b1;
        ld_val = CTR_W'(CLEAR_CYCLES - 1);
      end
      CLEAR: if (cnt_zero) begin
        state_n = num_q != '0 ? RUN : drain_st;
        ld = 1'b1;
        ld_val = num_q != '0 ? num_q - CTR_W'(1) : drain_ld;
      end
      RUN: if (cnt_zero) begin
        state_n = drain_st;
        ld = 1'b1;
        ld_val = drain_ld;
      end
      DRAIN: if (cnt_zero) state_n = CAPTURE;
      CAPTURE: if (cap_q) state_n = DONE;
      DONE: state_n = IDLE;
      default: state_n = IDLE;
    endcase
    if (abort_go) begin
      state_n = CAPTURE;
      ld = 1'b0;
    end
  end
  seq_counter #(.W(CTR_W)) u_ctr (
    .clk_dut(clk_dut),
    .reset(reset),
    .ld(ld),
    .ld_val(ld_val),
    .dec(timed && !ld),
    .zero(cnt_zero)
  );
  // outputs are registered from the next state so they change on state-entry edges
  always_ff @(posedge clk_dut or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cap_q <= 1'b0;
      num_q <= '0;
      drain_q <= '0;
      o_tb_reset <= 1'b1;
      o_enable <= 1'b0;
      o_freeze <= 1'b0;
      o_busy <= 1'b0;
      o_done <= 1'b0;
      o_pass <= 1'b0;
      o_aborted <= 1'b0;
      o_res_data <= '0;
      o_res_events <= '0;
    end else begin
      state <= state_n;
      cap_q <= state == CAPTURE && state_n == CAPTURE;
      o_tb_reset <= state_n == CLEAR;
      o_enable <= state_n == RUN;
      o_busy <= state_n != IDLE;
      o_done <= state_n == DONE;
      o_freeze <= state_n == CAPTURE || (o_freeze && !start_go);
      o_aborted <= abort_go || (o_aborted && !start_go);
      if (start_go) begin
        num_q <= i_num_vectors;
        drain_q <= i_drain;
      end
      // capture lands on the second CAPTURE cycle, after the freeze has settled
      if (start_go) begin
        o_pass <= 1'b0;
        o_res_data <= '0;
        o_res_events <= '0;
      end else if (state_n == DONE) begin
        o_res_data <= i_data_ctr;
        o_res_events <= i_event_ctr;
        o_pass <= i_event_ctr == '0 && !o_aborted;
      end
    end
  end
endmodule

// File: tb/tb_test_sequencer.sv
// tb_test_sequencer: table-driven self-checking bench for test_sequencer
module tb_test_sequencer;
  logic clk_dut = 1'b0;
  logic reset = 1'b0;
  logic i_start = 1'b0;
  logic i_abort = 1'b0;
  logic [31:0] i_num_vectors = '0;
  logic [7:0] i_drain = '0;
  logic [31:0] i_data_ctr = '0;
  logic [31:0] i_event_ctr = '0;
  logic o_tb_reset, o_enable, o_freeze, o_busy, o_done, o_pass, o_aborted;
  logic [31:0] o_res_data, o_res_events;
  int checks = 0;
  int failures = 0;
  test_sequencer #(.CLEAR_CYCLES(4), .CTR_W(32)) dut (
    .clk_dut(clk_dut),
    .reset(reset),
    .i_start(i_start),
    .i_abort(i_abort),
    .i_num_vectors(i_num_vectors),
    .i_drain(i_drain),
    .i_data_ctr(i_data_ctr),
    .i_event_ctr(i_event_ctr),
    .o_tb_reset(o_tb_reset),
    .o_enable(o_enable),
    .o_freeze(o_freeze),
    .o_busy(o_busy),
    .o_done(o_done),
    .o_pass(o_pass),
    .o_aborted(o_aborted),
    .o_res_data(o_res_data),
    .o_res_events(o_res_events)
  );
  always #5 clk_dut = ~clk_dut;
  typedef struct {
    logic [31:0] num;
    logic [7:0]  drain;
    logic [31:0] data;
    logic [31:0] events;
    int          abort_t;
    int          restart_t;
    int          exp_en;
    int          exp_tbr;
    int          exp_lat;
    logic        exp_pass;
    logic        exp_abt;
  } vec_t;
  vec_t vt[11];
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask
  // start a run, then count enable/tb_reset cycles and edges until o_done
  task automatic do_run(input vec_t v, output int en, output int tbr, output int lat, output logic fz0);
    i_num_vectors = v.num;
    i_drain = v.drain;
    i_data_ctr = v.data;
    i_event_ctr = v.events;
    i_start = 1'b1;
    @(posedge clk_dut); #1;
    i_start = 1'b0;
    fz0 = o_freeze;
    en = 0;
    tbr = 0;
    lat = 0;
    while (!o_done && lat < 2000) begin
      if (o_enable) en++;
      if (o_tb_reset) tbr++;
      i_abort = v.abort_t == lat + 1;
      i_start = v.restart_t == lat + 1;
      @(posedge clk_dut); #1;
      lat++;
    end
    i_abort = 1'b0;
    i_start = 1'b0;
  endtask
  initial begin
    int en, tbr, lat;
    logic fz0, seen;
    //        num  drn data ev abt rst en tbr lat pass abt
    vt[0]  = '{10,  3, 10, 0,  0, 0, 10, 4, 19, 1'b1, 1'b0};
    vt[1]  = '{5,   2, 5,  2,  0, 0, 5,  4, 13, 1'b0, 1'b0};
    vt[2]  = '{0,   0, 0,  0,  0, 0, 0,  4, 6,  1'b1, 1'b0};
    vt[3]  = '{100, 3, 20, 0, 24, 0, 20, 4, 26, 1'b0, 1'b1};
    vt[4]  = '{10,  3, 10, 0,  0, 7, 10, 4, 19, 1'b1, 1'b0};
    vt[5]  = '{0,   3, 0,  1,  0, 0, 0,  4, 9,  1'b0, 1'b0};
    vt[6]  = '{1,   0, 1,  0,  0, 0, 1,  4, 7,  1'b1, 1'b0};
    vt[7]  = '{10,  0, 7,  0,  2, 0, 0,  2, 4,  1'b0, 1'b1};
    vt[8]  = '{3,   5, 3,  0,  9, 0, 3,  4, 11, 1'b0, 1'b1};
    vt[9]  = '{5,   2, 5,  0,  9, 0, 5,  4, 11, 1'b0, 1'b1};
    vt[10] = '{3, 255, 3,  0,  0, 0, 3,  4, 264, 1'b1, 1'b0};
    #1 reset = 1'b1;
    #1;
    chk("rst_tb_reset", 64'(o_tb_reset), 64'd1);
    chk("rst_flags", 64'({o_enable, o_freeze, o_busy, o_done, o_pass, o_aborted}), 64'd0);
    chk("rst_res", 64'(o_res_data | o_res_events), 64'd0);
    repeat (2) @(posedge clk_dut);
    #1 reset = 1'b0;
    @(posedge clk_dut); #1;
    chk("rel_tb_reset", 64'(o_tb_reset), 64'd0);
    chk("rel_busy", 64'(o_busy), 64'd0);
    for (int i = 0; i < 11; i++) begin
      do_run(vt[i], en, tbr, lat, fz0);
      chk($sformatf("v%0d_freeze_clr", i), 64'(fz0), 64'd0);
      chk($sformatf("v%0d_enable_cycles", i), 64'(en), 64'(vt[i].exp_en));
      chk($sformatf("v%0d_tb_reset_cycles", i), 64'(tbr), 64'(vt[i].exp_tbr));
      chk($sformatf("v%0d_done_latency", i), 64'(lat), 64'(vt[i].exp_lat));
      chk($sformatf("v%0d_pass", i), 64'(o_pass), 64'(vt[i].exp_pass));
      chk($sformatf("v%0d_aborted", i), 64'(o_aborted), 64'(vt[i].exp_abt));
      chk($sformatf("v%0d_res_data", i), 64'(o_res_data), 64'(vt[i].data));
      chk($sformatf("v%0d_res_events", i), 64'(o_res_events), 64'(vt[i].events));
      chk($sformatf("v%0d_freeze_done", i), 64'(o_freeze), 64'd1);
      @(posedge clk_dut); #1;
      chk($sformatf("v%0d_done_pulse", i), 64'(o_done), 64'd0);
      chk($sformatf("v%0d_idle_busy", i), 64'(o_busy), 64'd0);
      chk($sformatf("v%0d_freeze_held", i), 64'(o_freeze), 64'd1);
      chk($sformatf("v%0d_res_held", i), 64'(o_res_events), 64'(vt[i].events));
    end
    i_num_vectors = 50;
    i_drain = 0;
    i_start = 1'b1;
    @(posedge clk_dut); #1;
    i_start = 1'b0;
    repeat (10) @(posedge clk_dut);
    #1;
    chk("midrun_enable", 64'(o_enable), 64'd1);
    #2 reset = 1'b1;
    #1;
    chk("midrun_rst_enable", 64'(o_enable), 64'd0);
    chk("midrun_rst_busy", 64'(o_busy), 64'd0);
    chk("midrun_rst_tb_reset", 64'(o_tb_reset), 64'd1);
    chk("midrun_rst_flags", 64'({o_freeze, o_done, o_pass, o_aborted}), 64'd0);
    chk("midrun_rst_res", 64'(o_res_data | o_res_events), 64'd0);
    @(posedge clk_dut); #1;
    reset = 1'b0;
    seen = 1'b0;
    repeat (80) begin
      @(posedge clk_dut); #1;
      if (o_done || o_enable) seen = 1'b1;
    end
    chk("midrun_no_done", 64'(seen), 64'd0);
    chk("midrun_idle", 64'(o_busy), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/test_sequencer.md
TEST_SEQUENCER -- requirements
Module: test_sequencer

Interface
REQ-001 Parameter: CLEAR_CYCLES, 4, cycles o_tb_reset is held high at run start; legal range 1..255.
REQ-002 Parameter: CTR_W, 32, width of vector counter and captured counters.
REQ-003 Port: clk_dut  input  1  single clock for all logic.
REQ-004 Port: reset  input  1  asynchronous, active-high reset.
REQ-005 Port: i_start  input  1  one-cycle request to begin a run; sampled only in IDLE.
REQ-006 Port: i_abort  input  1  terminate an in-progress run.
REQ-007 Port: i_num_vectors  input  CTR_W  vectors to apply; latched on accepted i_start.
REQ-008 Port: i_drain  input  8  pipeline drain cycles after last vector; latched on accepted i_start.
REQ-009 Port: i_data_ctr  input  CTR_W  testbench data counter.
REQ-010 Port: i_event_ctr  input  CTR_W  testbench event (mismatch) counter.
REQ-011 Port: o_tb_reset  output  1  reset to randomisers, driver, monitor and scoreboard.
REQ-012 Port: o_enable  output  1  randomiser enable.
REQ-013 Port: o_freeze  output  1  scoreboard freeze.
REQ-014 Port: o_busy  output  1  high in every state except IDLE.
REQ-015 Port: o_done  output  1  one-cycle pulse at run completion.
REQ-016 Port: o_pass  output  1  captured event count is zero and run was not aborted.
REQ-017 Port: o_aborted  output  1  last run ended by i_abort.
REQ-018 Port: o_res_data / o_res_events  output  CTR_W each  captured counters.

Function
REQ-019 FSM states SHALL be: IDLE, CLEAR, RUN, DRAIN, CAPTURE, DONE.
REQ-020 IDLE: i_start=1 -> CLEAR; latch i_num_vectors and i_drain; clear o_freeze, o_aborted, o_pass, o_res_*.
REQ-021 i_start in any state other than IDLE SHALL be ignored.
REQ-022 CLEAR: o_tb_reset=1 for exactly CLEAR_CYCLES cycles, then RUN; if the latched count is 0, go to DRAIN instead.
REQ-023 RUN: o_enable=1 for exactly the latched count of consecutive cycles, then DRAIN; the down-counter is CTR_W wide, so 2^CTR_W-1 is the largest run.
REQ-024 DRAIN: o_enable=0 for exactly the latched i_drain cycles (0 means none), then CAPTURE.
REQ-025 CAPTURE: o_freeze=1 is asserted on entry; the counters are registered into o_res_* on the second CAPTURE cycle (one cycle after freeze takes effect), then DONE.
REQ-026 DONE: o_done=1 for one cycle; o_pass=(o_res_events==0)&&!o_aborted; then IDLE.
REQ-027 o_freeze SHALL remain high from CAPTURE through IDLE until the next accepted i_start, so results stay visible.
REQ-028 i_abort in CLEAR, RUN or DRAIN SHALL deassert o_enable next cycle, set o_aborted, and go to CAPTURE; it is ignored in other states.
REQ-029 If i_abort and RUN's last-vector condition coincide, abort SHALL take priority (o_aborted=1).
REQ-030 All outputs SHALL be registered; o_enable changes exactly on state-entry edges.

Reset
REQ-031 On reset: state=IDLE; o_tb_reset=1 while reset is asserted, and 0 in the first cycle after release; all other outputs 0; counters 0.
REQ-032 Reset asserted mid-run SHALL abandon the run with no o_done pulse; the captured results are cleared.

Structure
REQ-033 The FSM state encoding and the CLEAR_CYCLES default SHALL live in the shared testbench package; the testbench top instantiates test_sequencer alongside the scoreboard.
REQ-034 A single sub-module, seq_counter (loadable down-counter with zero flag), SHALL be reused for the CLEAR, RUN and DRAIN timing.

Verification
REQ-035 i_start, N=10, drain=3, event_ctr=0, data_ctr=10 -> o_enable high exactly 10 cycles; o_done 4+10+3+2 cycles later; o_pass=1; o_res_data=10.
REQ-036 N=5, event_ctr=2 at capture -> o_pass=0, o_res_events=2, o_freeze held after o_done.
REQ-037 N=0, drain=0 -> o_enable never asserts; o_done follows CLEAR+CAPTURE; o_pass=1 if event_ctr=0.
REQ-038 N=100, i_abort at the 20th enabled cycle -> o_enable low next cycle; o_aborted=1; o_pass=0; o_done pulses.
REQ-039 i_start repeated during RUN -> no effect on count or timing; reset mid-RUN -> all outputs 0 asynchronously, no o_done.
REQ-040 Back-to-back runs: a second i_start in the cycle after o_done -> o_freeze clears and o_tb_reset re-asserts for CLEAR_CYCLES.
